// File: rtl/distance_filter.sv
// distance_filter
//   Smooths the ultrasonic driver's raw cm readings with a DEPTH-sample
//   moving average, drives a hysteretic obstacle flag from the average and
//   raises a stale flag when no usable reading has arrived for
//   TIMEOUT_CYCLES cycles. Zero readings (no echo / too close) are dropped.
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active-high
//   distance_in    raw distance in cm
//   sample_valid   one-cycle strobe qualifying distance_in
//   filt_distance  registered moving average (cm), updated on every accept
//   filt_valid     one-cycle pulse once the window is full and the average updates
//   obstacle       NEAR state of the hysteresis FSM, OR'd with stale
//   stale          no accepted sample for TIMEOUT_CYCLES cycles
module distance_filter #(
  parameter int          DEPTH          = 4,
  parameter logic [7:0]  NEAR_CM        = 8'd20,
  parameter logic [7:0]  FAR_CM         = 8'd25,
  parameter logic [25:0] TIMEOUT_CYCLES = 26'd50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] distance_in,
  input  logic       sample_valid,
  output logic [7:0] filt_distance,
  output logic       filt_valid,
  output logic       obstacle,
  output logic       stale
);

  localparam int LOG2D = $clog2(DEPTH);
  localparam int SW    = 8 + LOG2D;          // DEPTH * 255 always fits
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic {CLEAR = 1'b0, NEAR = 1'b1} state_t;

  logic [7:0]       win_buf [DEPTH];
  logic [SW-1:0]    sum;
  logic [LOG2D-1:0] wr_ptr;
  logic [CW-1:0]    fill_cnt;
  logic [25:0]      to_cnt;
  state_t           state;

  logic             accept;
  logic             zero_strobe;
  logic [SW-1:0]    sum_next;
  logic [7:0]       avg_next;
  logic [CW-1:0]    fill_next;
  logic             full_next;
  logic [25:0]      to_next;
  logic             stale_next;
  state_t           state_next;

  assign accept      = sample_valid && (distance_in != 8'd0);
  assign zero_strobe = sample_valid && (distance_in == 8'd0);

  always_comb begin
    // Oldest entry leaves the window as the new one enters.
    sum_next  = sum - SW'(win_buf[wr_ptr]) + SW'(distance_in);
    avg_next  = 8'(sum_next >> LOG2D);
    fill_next = (fill_cnt == CW'(DEPTH)) ? fill_cnt : fill_cnt + CW'(1);
    full_next = (fill_next == CW'(DEPTH));
  end

  // Timeout counter: cleared by an accept, frozen by a rejected (zero)
  // strobe, otherwise counts up and saturates.
  always_comb begin
    to_next = to_cnt;
    if (accept)
      to_next = '0;
    else if (!zero_strobe && (to_cnt != TIMEOUT_CYCLES))
      to_next = to_cnt + 26'd1;
    stale_next = (to_next == TIMEOUT_CYCLES);
  end

  // Hysteresis is only evaluated on a full-window update; warm-up averages
  // are built from too few samples to act on.
  always_comb begin
    state_next = state;
    if (accept && full_next) begin
      case (state)
        CLEAR:   if (avg_next < NEAR_CM) state_next = NEAR;
        NEAR:    if (avg_next >= FAR_CM) state_next = CLEAR;
        default: state_next = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) win_buf[i] <= 8'd0;
      sum           <= '0;
      wr_ptr        <= '0;
      fill_cnt      <= '0;
      to_cnt        <= '0;
      state         <= CLEAR;
      filt_distance <= 8'd0;
      filt_valid    <= 1'b0;
      obstacle      <= 1'b0;
      stale         <= 1'b0;
    end else begin
      to_cnt     <= to_next;
      stale      <= stale_next;
      state      <= state_next;
      // Stale forces the fail-safe indication without touching the FSM.
      obstacle   <= (state_next == NEAR) | stale_next;
      filt_valid <= accept && full_next;
      if (accept) begin
        win_buf[wr_ptr] <= distance_in;
        sum             <= sum_next;
        wr_ptr          <= wr_ptr + LOG2D'(1);  // DEPTH is a power of 2
        fill_cnt        <= fill_next;
        filt_distance   <= avg_next;
      end
    end
  end

endmodule

// File: tb/tb_distance_filter.sv
// Directed bench for distance_filter (DEPTH=4, NEAR=20, FAR=25,
// TIMEOUT_CYCLES=100). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point after the edge that consumed them.
module tb_distance_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] distance_in;
  logic       sample_valid;
  logic [7:0] filt_distance;
  logic       filt_valid;
  logic       obstacle;
  logic       stale;

  int checks = 0;
  int errors = 0;

  distance_filter #(
    .DEPTH(4), .NEAR_CM(8'd20), .FAR_CM(8'd25), .TIMEOUT_CYCLES(26'd100)
  ) dut (
    .clk(clk), .rst(rst), .distance_in(distance_in), .sample_valid(sample_valid),
    .filt_distance(filt_distance), .filt_valid(filt_valid),
    .obstacle(obstacle), .stale(stale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One strobe on the next edge; returns 1 unit after that edge.
  task automatic strobe(input logic [7:0] d);
    sample_valid = 1'b1;
    distance_in  = d;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    distance_in  = 8'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic v,
                         input logic ob, input logic st);
    chk({tag, ".dist"}, filt_distance, d);
    chk({tag, ".valid"}, filt_valid, v);
    chk({tag, ".obst"}, obstacle, ob);
    chk({tag, ".stale"}, stale, st);
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b0; distance_in = 8'd0;
    @(posedge clk); #1;
    idle(2);
    chk_out("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Warm-up: averages track sum/4 but no valid pulse until the 4th sample.
    strobe(8'd40); chk_out("warm1", 8'd10, 1'b0, 1'b0, 1'b0);
    idle(1);
    strobe(8'd40); chk_out("warm2", 8'd20, 1'b0, 1'b0, 1'b0);
    idle(2);
    strobe(8'd40); chk_out("warm3", 8'd30, 1'b0, 1'b0, 1'b0);
    strobe(8'd40); chk_out("warm4", 8'd40, 1'b1, 1'b0, 1'b0);
    idle(1);       chk("pulse_width", filt_valid, 1'b0);

    // Approach: back-to-back strobes, obstacle rises with the 17 average.
    strobe(8'd10); chk_out("appr1", 8'd32, 1'b1, 1'b0, 1'b0);
    strobe(8'd10); chk_out("appr2", 8'd25, 1'b1, 1'b0, 1'b0);
    strobe(8'd10); chk_out("appr3", 8'd17, 1'b1, 1'b1, 1'b0);
    strobe(8'd10); chk_out("appr4", 8'd10, 1'b1, 1'b1, 1'b0);

    // Hysteresis band 20..24 holds NEAR; 26 releases it.
    strobe(8'd22); chk_out("hyst1", 8'd13, 1'b1, 1'b1, 1'b0);
    strobe(8'd22); chk_out("hyst2", 8'd16, 1'b1, 1'b1, 1'b0);
    strobe(8'd22); chk_out("hyst3", 8'd19, 1'b1, 1'b1, 1'b0);
    strobe(8'd22); chk_out("hyst4", 8'd22, 1'b1, 1'b1, 1'b0);
    strobe(8'd30); chk_out("hyst5", 8'd24, 1'b1, 1'b1, 1'b0);
    strobe(8'd30); chk_out("hyst6", 8'd26, 1'b1, 1'b0, 1'b0);

    // Zero reading is ignored: window [30,30,22,22], next write hits a 22.
    strobe(8'd0);  chk_out("zero", 8'd26, 1'b0, 1'b0, 1'b0);
    strobe(8'd50); chk_out("after_zero", 8'd33, 1'b1, 1'b0, 1'b0);

    // Timeout: 49 idle + one zero strobe (counter holds) + 50 idle = 99.
    idle(49);
    strobe(8'd0);
    idle(50);      chk_out("to_edge99", 8'd33, 1'b0, 1'b0, 1'b0);
    idle(1);       chk_out("to_edge100", 8'd33, 1'b0, 1'b1, 1'b1);
    idle(3);       chk_out("to_sat", 8'd33, 1'b0, 1'b1, 1'b1);
    strobe(8'd50); chk_out("to_clear", 8'd40, 1'b1, 1'b0, 1'b0);

    // Saturated readings: window [30,30,50,50] -> all 255.
    strobe(8'd255); chk("sat1", filt_distance, 8'd96);
    strobe(8'd255); chk("sat2", filt_distance, 8'd152);
    strobe(8'd255); chk("sat3", filt_distance, 8'd203);
    strobe(8'd255); chk_out("sat4", 8'd255, 1'b1, 1'b0, 1'b0);

    // Reset wins over a coincident strobe and restarts warm-up from empty.
    rst = 1'b1;
    strobe(8'd100); chk_out("rst_strobe", 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    strobe(8'd60); chk_out("rewarm1", 8'd15, 1'b0, 1'b0, 1'b0);
    strobe(8'd60); chk_out("rewarm2", 8'd30, 1'b0, 1'b0, 1'b0);
    strobe(8'd60); chk_out("rewarm3", 8'd45, 1'b0, 1'b0, 1'b0);
    strobe(8'd60); chk_out("rewarm4", 8'd60, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
